// File: rtl/tile_clk_rst_ctrl.sv
// Per-tile clock-enable / reset sequencer: powers a tile up and down on a level
// request, draining NoC traffic (bounded by a timeout) before reset and clock gating.
module tile_clk_rst_ctrl #(
    parameter int unsigned RstCycles    = 8,
    parameter int unsigned IdleCycles   = 4,
    parameter int unsigned DrainTimeout = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tile_en_i,
    input  logic       tile_idle_i,
    output logic       tile_clk_en_o,
    output logic       tile_rst_no,
    output logic       isolate_o,
    output logic       busy_o,
    output logic       drain_timeout_o,
    output logic [2:0] state_o
);

    localparam int unsigned MaxCnt = (RstCycles > DrainTimeout) ? RstCycles : DrainTimeout;
    localparam int unsigned CntW   = $clog2(MaxCnt) + 1;

    localparam logic [CntW-1:0] RstLast  = CntW'(RstCycles - 1);
    localparam logic [CntW-1:0] IdleLast = CntW'(IdleCycles - 1);
    localparam logic [CntW-1:0] TmoLast  = CntW'(DrainTimeout - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [2:0] {
        OFF      = 3'd0,
        CLK_ON   = 3'd1,
        RUN      = 3'd2,
        DRAIN    = 3'd3,
        RST_HOLD = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            pulse_s;

    logic            clk_en_q, clk_en_d;
    logic            rst_n_q, rst_n_d;
    logic            iso_q, iso_d;
    logic            busy_q, busy_d;
    logic            dto_q;

    // Next-state and counter update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idle_cnt_d = idle_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        pulse_s    = 1'b0;
        case (state_q)
            OFF: begin
                if (tile_en_i) begin
                    state_d = CLK_ON;
                    cnt_d   = '0;
                end else begin
                    state_d = OFF;
                end
            end
            CLK_ON: begin
                cnt_d = cnt_q + CntOne;
                if (cnt_q == RstLast) begin
                    state_d = RUN;
                end else begin
                    state_d = CLK_ON;
                end
            end
            RUN: begin
                if (!tile_en_i) begin
                    state_d    = DRAIN;
                    idle_cnt_d = '0;
                    tmo_cnt_d  = '0;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                tmo_cnt_d = tmo_cnt_q + CntOne;
                if (tile_idle_i) begin
                    idle_cnt_d = idle_cnt_q + CntOne;
                end else begin
                    idle_cnt_d = '0;
                end
                // Abort beats idle completion, which beats timeout.
                if (tile_en_i) begin
                    state_d = RUN;
                end else if (tile_idle_i && (idle_cnt_q == IdleLast)) begin
                    state_d = RST_HOLD;
                    cnt_d   = '0;
                end else if (tmo_cnt_q == TmoLast) begin
                    state_d = RST_HOLD;
                    cnt_d   = '0;
                    pulse_s = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            RST_HOLD: begin
                cnt_d = cnt_q + CntOne;
                if (cnt_q == RstLast) begin
                    state_d = OFF;
                end else begin
                    state_d = RST_HOLD;
                end
            end
            default: begin
                state_d    = OFF;
                cnt_d      = '0;
                idle_cnt_d = '0;
                tmo_cnt_d  = '0;
            end
        endcase
    end

    // Output decode from the next state so outputs are flop-driven and aligned with state
    always_comb begin
        clk_en_d = 1'b0;
        rst_n_d  = 1'b0;
        iso_d    = 1'b1;
        busy_d   = 1'b0;
        case (state_d)
            OFF:      begin clk_en_d = 1'b0; rst_n_d = 1'b0; iso_d = 1'b1; busy_d = 1'b0; end
            CLK_ON:   begin clk_en_d = 1'b1; rst_n_d = 1'b0; iso_d = 1'b1; busy_d = 1'b1; end
            RUN:      begin clk_en_d = 1'b1; rst_n_d = 1'b1; iso_d = 1'b0; busy_d = 1'b0; end
            DRAIN:    begin clk_en_d = 1'b1; rst_n_d = 1'b1; iso_d = 1'b1; busy_d = 1'b1; end
            RST_HOLD: begin clk_en_d = 1'b1; rst_n_d = 1'b0; iso_d = 1'b1; busy_d = 1'b1; end
            default:  begin clk_en_d = 1'b0; rst_n_d = 1'b0; iso_d = 1'b1; busy_d = 1'b0; end
        endcase
    end

    // State, counters and output flops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= OFF;
            cnt_q      <= '0;
            idle_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            clk_en_q   <= 1'b0;
            rst_n_q    <= 1'b0;
            iso_q      <= 1'b1;
            busy_q     <= 1'b0;
            dto_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idle_cnt_q <= idle_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            clk_en_q   <= clk_en_d;
            rst_n_q    <= rst_n_d;
            iso_q      <= iso_d;
            busy_q     <= busy_d;
            dto_q      <= pulse_s;
        end
    end

    assign tile_clk_en_o   = clk_en_q;
    assign tile_rst_no     = rst_n_q;
    assign isolate_o       = iso_q;
    assign busy_o          = busy_q;
    assign drain_timeout_o = dto_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_tile_clk_rst_ctrl.sv
// Directed bench for tile_clk_rst_ctrl: a per-cycle phase/duration model plus
// literal duration and timing checks for each power sequence.
module tb_tile_clk_rst_ctrl;

    localparam int R = 8;
    localparam int I = 4;
    localparam int T = 32;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       tile_en_i;
    logic       tile_idle_i;
    logic       tile_clk_en_o;
    logic       tile_rst_no;
    logic       isolate_o;
    logic       busy_o;
    logic       drain_timeout_o;
    logic [2:0] state_o;

    tile_clk_rst_ctrl #(.RstCycles(R), .IdleCycles(I), .DrainTimeout(T)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .tile_en_i      (tile_en_i),
        .tile_idle_i    (tile_idle_i),
        .tile_clk_en_o  (tile_clk_en_o),
        .tile_rst_no    (tile_rst_no),
        .isolate_o      (isolate_o),
        .busy_o         (busy_o),
        .drain_timeout_o(drain_timeout_o),
        .state_o        (state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulse  = 0;

    // Model: current phase, cycles spent in it, idle streak, pending timeout pulse
    int m_phase  = 0;
    int m_len    = 0;
    int m_streak = 0;
    bit m_pulse  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // {clk_en, rst_n, isolate, busy} for each phase
    function automatic logic [3:0] phase_outs(input int p);
        logic [3:0] tbl [5];
        tbl[0] = 4'b0010;
        tbl[1] = 4'b1011;
        tbl[2] = 4'b1100;
        tbl[3] = 4'b1111;
        tbl[4] = 4'b1011;
        return tbl[p];
    endfunction

    function automatic int dut_vec();
        return int'({tile_clk_en_o, tile_rst_no, isolate_o, busy_o, drain_timeout_o, state_o});
    endfunction

    function automatic int model_vec();
        return int'({phase_outs(m_phase), m_pulse, 3'(m_phase)});
    endfunction

    task automatic model_reset();
        m_phase = 0; m_len = 0; m_streak = 0; m_pulse = 1'b0;
    endtask

    task automatic model_step();
        m_pulse = 1'b0;
        if (m_phase == 0) begin
            if (tile_en_i) begin m_phase = 1; m_len = 0; end
        end else if (m_phase == 1) begin
            m_len++;
            if (m_len == R) m_phase = 2;
        end else if (m_phase == 2) begin
            if (!tile_en_i) begin m_phase = 3; m_len = 0; m_streak = 0; end
        end else if (m_phase == 3) begin
            m_len++;
            m_streak = tile_idle_i ? m_streak + 1 : 0;
            if (tile_en_i) m_phase = 2;
            else if (m_streak >= I) begin m_phase = 4; m_len = 0; end
            else if (m_len >= T) begin m_phase = 4; m_len = 0; m_pulse = 1'b1; end
        end else begin
            m_len++;
            if (m_len == R) m_phase = 0;
        end
    endtask

    // One clock: advance model on the edge, compare on the falling edge
    task automatic tick();
        @(posedge clk_i);
        if (!rst_ni) model_reset();
        else model_step();
        @(negedge clk_i);
        if (drain_timeout_o) n_pulse++;
        chk("cycle_outputs", dut_vec(), model_vec());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Count cycles the DUT stays in state s, starting from the current cycle
    task automatic measure(input int s, output int len);
        len = 0;
        while (int'(state_o) == s && len < 200) begin
            len++;
            tick();
        end
    endtask

    task automatic power_up();
        int len;
        tile_en_i = 1'b1;
        tick();
        measure(1, len);
        chk("pwrup_clk_on_len", len, R);
    endtask

    int len;
    int pulses0;
    logic [7:0] idle_pat;

    initial begin
        rst_ni = 1'b0; tile_en_i = 1'b0; tile_idle_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset_outputs", dut_vec(), 32'h20);
        rst_ni = 1'b1;
        run(9);
        chk("off_state_held", int'(state_o), 0);

        // Power-up with exact edge timing
        tile_en_i = 1'b1;
        tick();
        chk("pwrup_clk_en", int'(tile_clk_en_o), 1);
        chk("pwrup_rst_low", int'(tile_rst_no), 0);
        chk("pwrup_busy", int'(busy_o), 1);
        run(R - 1);
        chk("pwrup_rst_still_low", int'(tile_rst_no), 0);
        tick();
        chk("pwrup_rst_released", int'({tile_rst_no, isolate_o, busy_o}), 3'b100);

        // Clean power-down
        pulses0 = n_pulse;
        tile_idle_i = 1'b1;
        tile_en_i   = 1'b0;
        tick();
        chk("pdn_isolate", int'(isolate_o), 1);
        measure(3, len);
        chk("clean_drain_len", len, I);
        measure(4, len);
        chk("clean_rsthold_len", len, R);
        chk("clean_off_clk_en", int'(tile_clk_en_o), 0);
        chk("clean_no_pulse", n_pulse - pulses0, 0);

        // Idle interrupted
        power_up();
        idle_pat = 8'b1111_0111;
        tile_en_i = 1'b0;
        tick();
        len = 0;
        while (state_o == 3'd3 && len < 40) begin
            tile_idle_i = (len < 8) ? idle_pat[len] : 1'b1;
            tick();
            len++;
        end
        chk("interrupted_drain_len", len, 8);
        measure(4, len);
        chk("interrupted_rsthold_len", len, R);

        // Timeout
        power_up();
        pulses0 = n_pulse;
        tile_idle_i = 1'b0;
        tile_en_i   = 1'b0;
        tick();
        measure(3, len);
        chk("timeout_drain_len", len, T);
        chk("timeout_pulse_now", int'(drain_timeout_o), 1);
        measure(4, len);
        chk("timeout_rsthold_len", len, R);
        chk("timeout_pulse_count", n_pulse - pulses0, 1);

        // Abort in drain cycle 2
        power_up();
        tile_en_i = 1'b0;
        run(2);
        chk("abort_in_drain", int'(state_o), 3);
        tile_en_i = 1'b1;
        tick();
        chk("abort_run", int'({state_o, isolate_o}), 4'b0100);

        // Async reset from RUN, then in CLK_ON cycle 3
        #1 rst_ni = 1'b0;
        #1 chk("async_rst_run", dut_vec(), 32'h20);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tile_en_i = 1'b1;
        run(3);
        chk("clk_on_cycle3", int'(state_o), 1);
        #1 rst_ni = 1'b0;
        #1 chk("async_rst_clk_on", dut_vec(), 32'h20);
        model_reset();
        tile_en_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        run(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
